// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

   localparam int RETRY_W = 4;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      WAIT  = 3'd1,
      RUN   = 3'd2,
      RETRY = 3'd3,
      FAIL  = 3'd4
   } state_e;

   // Wide enough to hold the largest cycle count plus headroom so no counter wraps.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs; flops reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL40_2 reset/lock sequencer: resets the PLL, waits for stable lock, releases core reset.
// Optional lock timeout in WAIT is enabled with `define PLL_LOCK_SEQ_TIMEOUT_EN.
module pll_lock_seq
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES      = 16,
   parameter int STABLE_CYCLES   = 1024,
   parameter int CORE_RST_CYCLES = 32,
   parameter int MAX_RETRIES     = 3,
   parameter int TIMEOUT_CYCLES  = 65536
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock,
   output logic               pll_resetb,
   output logic               pll_bypass,
   output logic               core_rst,
   output logic               pll_ready,
   output logic               pll_failed,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int CNT_W = cnt_width(RST_CYCLES, STABLE_CYCLES, CORE_RST_CYCLES);
   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
   localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               core_rst_q, core_rst_d;
   logic               lock_s;
   logic               tmo_hit;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_lock),
      .q_o (lock_s)
   );

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             seen_q, seen_d;

   // Once lock has been seen in this attempt the timeout can no longer fire.
   always_comb begin
      tmo_d  = tmo_q;
      seen_d = seen_q;
      if (state_q == WAIT) begin
         if (lock_s) seen_d = 1'b1;
         if (!seen_q && !lock_s && (tmo_q != TMO_LAST)) tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d  = '0;
         seen_d = 1'b0;
      end
   end

   assign tmo_hit = (state_q == WAIT) && !seen_q && !lock_s && (tmo_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q  <= '0;
         seen_q <= 1'b0;
      end else begin
         tmo_q  <= tmo_d;
         seen_q <= seen_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      core_rst_d = core_rst_q;
      unique case (state_q)
         HOLD: begin
            core_rst_d = 1'b1;
            if (cnt_q == RST_LAST) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            core_rst_d = 1'b1;
            if (tmo_hit) begin
               state_d = RETRY;
               cnt_d   = '0;
            end else if (!lock_s) begin
               cnt_d = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            // Lock loss outranks the core reset release on the same cycle.
            if (!lock_s) begin
               state_d    = RETRY;
               cnt_d      = '0;
               core_rst_d = 1'b1;
            end else if (cnt_q == CORE_LAST) begin
               core_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RETRY: begin
            core_rst_d = 1'b1;
            cnt_d      = '0;
            retry_d    = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
            state_d    = (retry_d >= RETRY_LIMIT) ? FAIL : HOLD;
         end
         FAIL: begin
            if (cnt_q == CORE_LAST) begin
               core_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = HOLD;
            cnt_d      = '0;
            core_rst_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         retry_q    <= '0;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         core_rst_q <= core_rst_d;
      end
   end

   // RETRY keeps RESETB high so the PLL sees exactly RST_CYCLES of reset in HOLD.
   assign pll_resetb = (state_q == WAIT) || (state_q == RUN) || (state_q == RETRY);
   assign pll_bypass = (state_q == FAIL);
   assign pll_failed = (state_q == FAIL);
   assign pll_ready  = (state_q == RUN);
   assign core_rst   = core_rst_q;
   assign retry_cnt  = retry_q;

endmodule
